// File: rtl/light_mode_fsm.sv
// ---------------------------------------------------------------------------
// light_mode_fsm
// Lamp brightness mode controller. Consumes single-cycle button strobes,
// steps OFF -> LOW -> MID -> HIGH -> OFF, drives a PWM lamp output and
// forces the lamp OFF after a programmable idle time in any on-mode.
// ---------------------------------------------------------------------------
module light_mode_fsm #(
    parameter int unsigned PWM_PERIOD      = 100,
    parameter int unsigned DUTY_LOW        = 25,
    parameter int unsigned DUTY_MID        = 50,
    parameter logic [31:0] AUTO_OFF_CYCLES = 32'd500_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_btn_next,
    input  logic       i_btn_off,
    output logic [1:0] o_mode,
    output logic       o_on,
    output logic       o_pwm,
    output logic       o_timeout
);

    // PWM counter spans 0..PWM_PERIOD-1; keep at least one bit
    localparam int unsigned     CNT_W       = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(PWM_PERIOD - 1);
    localparam logic [31:0]     IDLE_MAX    = 32'hFFFF_FFFF;
    // Idle count at which auto-off fires (only meaningful when enabled)
    localparam logic [31:0]     FIRE_AT     = AUTO_OFF_CYCLES - 32'd1;
    localparam logic            AUTO_OFF_EN = (AUTO_OFF_CYCLES != 32'd0);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_LOW  = 2'd1,
        ST_MID  = 2'd2,
        ST_HIGH = 2'd3
    } state_t;

    // High cycles per PWM period for a given mode; HIGH means always on
    function automatic logic [31:0] duty_of(input state_t st);
        logic [31:0] d;
        case (st)
            ST_OFF:  d = 32'd0;
            ST_LOW:  d = 32'(DUTY_LOW);
            ST_MID:  d = 32'(DUTY_MID);
            ST_HIGH: d = 32'(PWM_PERIOD);
            default: d = 32'd0;
        endcase
        return d;
    endfunction

    // Mode advance order with wrap back to OFF
    function automatic state_t advance(input state_t st);
        state_t n;
        case (st)
            ST_OFF:  n = ST_LOW;
            ST_LOW:  n = ST_MID;
            ST_MID:  n = ST_HIGH;
            ST_HIGH: n = ST_OFF;
            default: n = ST_OFF;
        endcase
        return n;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_pwm_cnt;
    logic [31:0]      r_idle_cnt;
    logic             r_on;
    logic             r_pwm;
    logic             r_timeout;

    logic             w_strobe;
    logic             w_fire;
    state_t           w_next_state;
    logic             w_state_chg;
    logic [CNT_W-1:0] w_pwm_cnt_next;
    logic [31:0]      w_idle_next;
    logic             w_pwm_next;

    // Next-state, counter and PWM decisions from pre-edge state and strobes
    always_comb begin
        w_strobe       = i_btn_next | i_btn_off;
        w_fire         = 1'b0;
        w_next_state   = r_state;
        w_state_chg    = 1'b0;
        w_pwm_cnt_next = '0;
        w_idle_next    = 32'd0;
        w_pwm_next     = 1'b0;

        // Auto-off fires only in an on-mode with no strobe on this edge
        if (AUTO_OFF_EN && (r_state != ST_OFF) && !w_strobe && (r_idle_cnt == FIRE_AT)) begin
            w_fire = 1'b1;
        end else begin
            w_fire = 1'b0;
        end

        // Off strobe wins over next; a strobe also cancels a pending timeout
        if (i_btn_off) begin
            w_next_state = ST_OFF;
        end else if (i_btn_next) begin
            w_next_state = advance(r_state);
        end else if (w_fire) begin
            w_next_state = ST_OFF;
        end else begin
            w_next_state = r_state;
        end

        w_state_chg = (w_next_state != r_state);

        // A mode change restarts the PWM period so the new duty starts clean
        if (w_state_chg) begin
            w_pwm_cnt_next = '0;
        end else if (r_pwm_cnt == CNT_MAX) begin
            w_pwm_cnt_next = '0;
        end else begin
            w_pwm_cnt_next = r_pwm_cnt + 1'b1;
        end

        // Idle time only accumulates while lit and undisturbed
        if (w_strobe || (r_state == ST_OFF)) begin
            w_idle_next = 32'd0;
        end else if (r_idle_cnt == IDLE_MAX) begin
            w_idle_next = r_idle_cnt;
        end else begin
            w_idle_next = r_idle_cnt + 32'd1;
        end

        // Compare in 32 bits so duty == PWM_PERIOD never overflows the counter width
        w_pwm_next = ({{(32 - CNT_W){1'b0}}, r_pwm_cnt} < duty_of(r_state));
    end

    // Mode FSM with registered outputs, counters and timeout pulse
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_OFF;
            r_pwm_cnt  <= '0;
            r_idle_cnt <= 32'd0;
            r_on       <= 1'b0;
            r_pwm      <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pwm_cnt  <= w_pwm_cnt_next;
            r_idle_cnt <= w_idle_next;
            r_on       <= (w_next_state != ST_OFF);
            r_pwm      <= w_pwm_next;
            r_timeout  <= w_fire;
        end
    end

    assign o_mode    = r_state;
    assign o_on      = r_on;
    assign o_pwm     = r_pwm;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_light_mode_fsm.sv
// ---------------------------------------------------------------------------
// tb_light_mode_fsm
// Directed bench for light_mode_fsm. Instance u_dut uses a short auto-off
// (50 cycles); instance u_dut_na has auto-off disabled.
// ---------------------------------------------------------------------------
module tb_light_mode_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_off = 1'b0;
    logic [1:0] mode;
    logic       on_s;
    logic       pwm;
    logic       timeout;

    logic       b_next = 1'b0;
    logic       b_off = 1'b0;
    logic [1:0] b_mode;
    logic       b_on;
    logic       b_pwm;
    logic       b_timeout;

    int n_checks = 0;
    int n_errors = 0;

    // 10 ns clock
    always #5 clk = ~clk;

    light_mode_fsm #(
        .PWM_PERIOD(10), .DUTY_LOW(3), .DUTY_MID(6), .AUTO_OFF_CYCLES(32'd50)
    ) u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_btn_next(btn_next), .i_btn_off(btn_off),
        .o_mode(mode), .o_on(on_s), .o_pwm(pwm), .o_timeout(timeout)
    );

    light_mode_fsm #(
        .PWM_PERIOD(10), .DUTY_LOW(3), .DUTY_MID(6), .AUTO_OFF_CYCLES(32'd0)
    ) u_dut_na (
        .i_clk(clk), .i_reset_n(rst_n), .i_btn_next(b_next), .i_btn_off(b_off),
        .o_mode(b_mode), .o_on(b_on), .o_pwm(b_pwm), .o_timeout(b_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_next();
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
    endtask

    task automatic pulse_off();
        btn_off = 1'b1;
        tick();
        btn_off = 1'b0;
    endtask

    int          highs;
    int          bad;
    int          touts;
    logic [1:0]  exp_mode;
    int          duty_tab [4] = '{3, 6, 10, 0};

    initial begin
        // ---------------- reset state ----------------
        rst_n = 1'b0;
        tick();
        tick();
        check_eq("rst_mode", {30'd0, mode}, 32'd0);
        check_eq("rst_on", {31'd0, on_s}, 32'd0);
        check_eq("rst_pwm", {31'd0, pwm}, 32'd0);
        check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- 1: async reset mid-run ----------------
        pulse_next();
        pulse_next();
        pulse_next();
        tick();
        tick();
        check_eq("pre_rst_mode", {30'd0, mode}, 32'd3);
        check_eq("pre_rst_pwm", {31'd0, pwm}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_mode", {30'd0, mode}, 32'd0);
        check_eq("async_rst_on", {31'd0, on_s}, 32'd0);
        check_eq("async_rst_pwm", {31'd0, pwm}, 32'd0);
        #2;
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (mode != 2'd0 || pwm != 1'b0 || timeout != 1'b0) bad++;
        end
        check_eq("idle_after_rst", bad, 32'd0);

        // ---------------- 2: mode stepping and PWM duty ----------------
        exp_mode = 2'd0;
        for (int i = 0; i < 4; i++) begin
            exp_mode = exp_mode + 2'd1;
            pulse_next();
            check_eq("step_mode", {30'd0, mode}, {30'd0, exp_mode});
            if (i == 0) check_eq("pwm_lag_low", {31'd0, pwm}, 32'd0);
            highs = 0;
            for (int k = 1; k <= 10; k++) begin
                tick();
                if (i == 0 && k == 1) check_eq("pwm_first_high", {31'd0, pwm}, 32'd1);
                highs += int'(pwm);
            end
            check_eq("pwm_window", highs, duty_tab[i]);
            for (int k = 0; k < 19; k++) tick();
        end

        // ---------------- 3: simultaneous next+off ----------------
        pulse_next();
        pulse_next();
        check_eq("mid_mode", {30'd0, mode}, 32'd2);
        check_eq("mid_on", {31'd0, on_s}, 32'd1);
        btn_next = 1'b1;
        btn_off  = 1'b1;
        tick();
        btn_next = 1'b0;
        btn_off  = 1'b0;
        check_eq("both_mode", {30'd0, mode}, 32'd0);
        check_eq("both_on", {31'd0, on_s}, 32'd0);

        // ---------------- 4: auto-off timing ----------------
        pulse_next();
        bad = 0;
        touts = 0;
        for (int k = 1; k <= 49; k++) begin
            tick();
            if (mode != 2'd1) bad++;
            touts += int'(timeout);
        end
        check_eq("ao_hold_mode", bad, 32'd0);
        check_eq("ao_no_early_to", touts, 32'd0);
        tick();
        check_eq("ao_fire_mode", {30'd0, mode}, 32'd0);
        check_eq("ao_fire_on", {31'd0, on_s}, 32'd0);
        check_eq("ao_timeout_hi", {31'd0, timeout}, 32'd1);
        tick();
        check_eq("ao_timeout_lo", {31'd0, timeout}, 32'd0);

        pulse_next();
        touts = 0;
        for (int k = 1; k <= 49; k++) begin
            tick();
            touts += int'(timeout);
        end
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        check_eq("ao_cancel_mode", {30'd0, mode}, 32'd2);
        touts += int'(timeout);
        tick();
        touts += int'(timeout);
        check_eq("ao_cancel_to", touts, 32'd0);
        check_eq("ao_cancel_hold", {30'd0, mode}, 32'd2);
        pulse_off();
        check_eq("ao_off_mode", {30'd0, mode}, 32'd0);

        // ---------------- 5: periodic strobes never time out ----------------
        pulse_next();
        pulse_next();
        pulse_next();
        check_eq("high_mode", {30'd0, mode}, 32'd3);
        exp_mode = 2'd3;
        bad = 0;
        touts = 0;
        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < 39; k++) begin
                tick();
                if (mode != exp_mode) bad++;
                touts += int'(timeout);
            end
            exp_mode = exp_mode + 2'd1;
            pulse_next();
            check_eq("wrap_mode", {30'd0, mode}, {30'd0, exp_mode});
        end
        check_eq("wrap_hold", bad, 32'd0);
        check_eq("wrap_no_to", touts, 32'd0);
        pulse_off();

        // ---------------- 6: auto-off disabled ----------------
        b_next = 1'b1;
        tick();
        b_next = 1'b0;
        check_eq("na_mode", {30'd0, b_mode}, 32'd1);
        bad = 0;
        touts = 0;
        highs = 0;
        for (int k = 1; k <= 10000; k++) begin
            tick();
            if (b_mode != 2'd1) bad++;
            touts += int'(b_timeout);
            if (k <= 10) highs += int'(b_pwm);
        end
        check_eq("na_hold", bad, 32'd0);
        check_eq("na_no_to", touts, 32'd0);
        check_eq("na_pwm_window", highs, 32'd3);
        b_off = 1'b1;
        tick();
        b_off = 1'b0;
        check_eq("na_off_mode", {30'd0, b_mode}, 32'd0);
        b_off = 1'b1;
        tick();
        b_off = 1'b0;
        check_eq("na_off_again", {30'd0, b_mode}, 32'd0);
        highs = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            highs += int'(b_pwm);
        end
        check_eq("na_off_pwm", highs, 32'd0);
        check_eq("na_off_on", {31'd0, b_on}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
